// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, frame-locked arbiter sharing one UART transmitter
module uart_tx_arbiter #(
  parameter int BUSY_TIMEOUT = 32,
  parameter int TO_W         = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_valid,
  input  logic [7:0] a_data,
  input  logic       a_last,
  output logic       a_ready,
  input  logic       b_valid,
  input  logic [7:0] b_data,
  input  logic       b_last,
  output logic       b_ready,
  output logic [7:0] to_tx,
  output logic       tx_start,
  input  logic       busy,
  output logic [1:0] grant,
  output logic       tx_timeout
);

  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_IDLE} state_t;

  localparam logic [TO_W-1:0] TO_PRE  = TO_W'(BUSY_TIMEOUT - 2);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(BUSY_TIMEOUT - 1);

  state_t          state;
  logic            lock;
  logic            owner_b;
  logic            rr_ptr;
  logic            last_q;
  logic [TO_W-1:0] to_cnt;
  logic            cand_a;
  logic            cand_b;
  logic            sel_last;
  logic            accept;

  // While a frame is locked only the owner may be picked; otherwise rr_ptr breaks ties.
  always_comb begin
    cand_a = 1'b0;
    cand_b = 1'b0;
    if (lock) begin
      cand_a = !owner_b && a_valid;
      cand_b = owner_b && b_valid;
    end else if (a_valid && b_valid) begin
      cand_a = !rr_ptr;
      cand_b = rr_ptr;
    end else begin
      cand_a = a_valid;
      cand_b = b_valid;
    end
    sel_last = cand_b ? b_last : a_last;
  end

  assign accept  = (state == IDLE) && !busy && (cand_a || cand_b);
  assign a_ready = accept && cand_a;
  assign b_ready = accept && cand_b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      to_tx      <= 8'h00;
      tx_start   <= 1'b0;
      grant      <= 2'b00;
      tx_timeout <= 1'b0;
      lock       <= 1'b0;
      owner_b    <= 1'b0;
      rr_ptr     <= 1'b0;
      last_q     <= 1'b0;
      to_cnt     <= '0;
    end else begin
      tx_start   <= 1'b0;
      tx_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            to_tx    <= cand_b ? b_data : a_data;
            last_q   <= sel_last;
            grant    <= {cand_b, cand_a};
            tx_start <= 1'b1;
            state    <= START;
            if (sel_last) begin
              lock   <= 1'b0;
              rr_ptr <= cand_a;
            end else begin
              lock    <= 1'b1;
              owner_b <= cand_b;
            end
          end
        end
        START: begin
          to_cnt <= '0;
          state  <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (busy) begin
            state <= WAIT_IDLE;
          end else if (to_cnt == TO_LAST) begin
            // Byte counts as consumed; a locked frame keeps its lock and grant.
            state <= IDLE;
            if (last_q) grant <= 2'b00;
          end else begin
            to_cnt <= to_cnt + 1'b1;
            if (to_cnt == TO_PRE) tx_timeout <= 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (!busy) begin
            state <= IDLE;
            if (last_q) grant <= 2'b00;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
